// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared load/store width codes, FSM state constants and width normalisation.
package mem_access_pkg;
  typedef enum logic [2:0] {
    MW_B  = 3'b000,
    MW_H  = 3'b001,
    MW_W  = 3'b010,
    MW_BU = 3'b100,
    MW_HU = 3'b101
  } mem_width_e;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;
  // Reserved funct3 codes behave as a full word.
  function automatic mem_width_e norm_width(input logic [2:0] f);
    return (f inside {3'b000, 3'b001, 3'b100, 3'b101}) ? mem_width_e'(f) : MW_W;
  endfunction
endpackage

// File: rtl/load_formatter.sv
// load_formatter: selects the addressed byte/half of a read word and sign- or zero-extends it.
module load_formatter
  import mem_access_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  lane_i,
  input  mem_width_e  width_i,
  output logic [31:0] result_o
);
  logic [31:0] sh;
  assign sh = rdata_i >> {lane_i, 3'b000};
  always_comb
    result_o = (width_i == MW_B)  ? {{24{sh[7]}}, sh[7:0]} :
               (width_i == MW_BU) ? {24'b0, sh[7:0]} :
               (width_i == MW_H)  ? {{16{sh[15]}}, sh[15:0]} :
               (width_i == MW_HU) ? {16'b0, sh[15:0]} : rdata_i;
endmodule

// File: rtl/mem_access.sv
// mem_access: memory stage with req/ack data-memory handshake and load formatting.
// Optional bus-error timeout in WAIT is enabled by defining MEM_TIMEOUT_EN.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [31:0] alu_result,
  input  logic [31:0] rs2_data,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  mem_width,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        valid_out,
  output logic [31:0] mem_result,
  output logic        misaligned,
  output logic        bus_error
);
  logic [0:0]  state_q, state_d;
  logic        req_q, req_d, we_q, we_d, valid_q, valid_d, mis_q, mis_d, berr_q, berr_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, result_q, result_d, fmt, wd_st;
  logic [3:0]  be_q, be_d, be_st;
  mem_width_e  width_q, width_d, w;
  logic        byte_op, half_op, memop, mis, acc, issue, ack_done, tout;
  assign w        = norm_width(mem_width);
  assign byte_op  = (w == MW_B) || (w == MW_BU);
  assign half_op  = (w == MW_H) || (w == MW_HU);
  assign memop    = mem_read | mem_write;
  assign mis      = (half_op && alu_result[0]) || (w == MW_W && alu_result[1:0] != 2'b00);
  assign acc      = (state_q == ST_IDLE) && valid_in;
  assign issue    = acc && memop && !mis;
  assign ack_done = (state_q == ST_WAIT) && req_q && dmem_ack;
  assign be_st    = byte_op ? 4'b0001 << alu_result[1:0] : half_op ? 4'b0011 << alu_result[1:0] : 4'b1111;
  assign wd_st    = byte_op ? {4{rs2_data[7:0]}} : half_op ? {2{rs2_data[15:0]}} : rs2_data;
`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q;
  assign tout = (state_q == ST_WAIT) && !dmem_ack && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge clk)
    if (rst) cnt_q <= '0;
    else     cnt_q <= (state_q == ST_WAIT) ? cnt_q + 1'b1 : '0;
`else
  assign tout = 1'b0;
`endif
  load_formatter u_fmt (
    .rdata_i  (dmem_rdata),
    .lane_i   (addr_q[1:0]),
    .width_i  (width_q),
    .result_o (fmt)
  );
  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    width_d  = width_q;
    valid_d  = 1'b0;
    result_d = result_q;
    mis_d    = 1'b0;
    berr_d   = 1'b0;
    if (acc && !issue) begin
      valid_d  = 1'b1;
      result_d = alu_result;
      mis_d    = memop;
    end else if (issue) begin
      state_d = ST_WAIT;
      req_d   = 1'b1;
      we_d    = mem_write;
      addr_d  = alu_result;
      wdata_d = mem_write ? wd_st : 32'h0;
      be_d    = mem_write ? be_st : 4'b1111;
      width_d = w;
    end else if (ack_done || tout) begin
      state_d  = ST_IDLE;
      req_d    = 1'b0;
      valid_d  = 1'b1;
      berr_d   = tout;
      result_d = tout ? 32'h0 : we_q ? addr_q : fmt;
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q  <= ST_IDLE;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      width_q  <= MW_B;
      valid_q  <= 1'b0;
      result_q <= '0;
      mis_q    <= 1'b0;
      berr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      width_q  <= width_d;
      valid_q  <= valid_d;
      result_q <= result_d;
      mis_q    <= mis_d;
      berr_q   <= berr_d;
    end
  assign stall      = (state_q == ST_WAIT);
  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = {addr_q[31:2], 2'b00};
  assign dmem_wdata = wdata_q;
  assign dmem_be    = be_q;
  assign valid_out  = valid_q;
  assign mem_result = result_q;
  assign misaligned = mis_q;
  assign bus_error  = berr_q;
endmodule
